// File: rtl/core_pkg.sv
// Shared definitions for the RV32 pipeline: datapath sizing defaults,
// ALU operation encodings and the operand forward-select type.
package core_pkg;

    // Datapath sizing defaults
    localparam int CORE_WIDTH  = 32;
    localparam int CORE_REG_AW = 5;

    // ALU operation encodings, matching the ALU's decoder
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_PASSB = 3'b101;  // LUI: pass operand B through
    localparam logic [2:0] ALU_SLL   = 3'b110;
    localparam logic [2:0] ALU_SRL   = 3'b111;

    // Where an EX operand comes from
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,  // value read from the register file in ID
        FWD_WB  = 2'b01,  // result being written back
        FWD_MEM = 2'b10   // ALU result sitting in MEM
    } fwd_sel_t;

endpackage : core_pkg

// File: rtl/id_ex_stage_hazard_unit.sv
// Hazard unit for the ID/EX boundary (purely combinational).
// Produces the operand forward selects, the branch/jump redirect and the
// stall/flush controls for F, D and E.
// Build option EX_FORWARD_EN: when defined, operands are forwarded from
// MEM/WB and only load-use pairs stall. When undefined, nothing is forwarded
// and any in-flight writer in E or M whose destination is read in D stalls.
module hazard_unit
    import core_pkg::*;
#(
    parameter int REG_AW = CORE_REG_AW
) (
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteE,
    input  logic              MemReadE,
    input  logic              BranchE,
    input  logic              JumpE,
    input  logic              ZeroE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    output fwd_sel_t          ForwardAE,
    output fwd_sel_t          ForwardBE,
    output logic              PCSrcE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE
);

    logic stall_c;

    // Redirect fetch on a taken branch (ZeroE = operands differ) or any jump
    always_comb begin
        PCSrcE = (BranchE & ZeroE) | JumpE;
    end

`ifdef EX_FORWARD_EN
    logic lwStall;
    logic unused_hz;

    // RegWriteE only matters to the no-forward stall rule
    assign unused_hz = RegWriteE;

    // Forward selects: MEM beats WB, and x0 is never forwarded
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (RegWriteM && (RdM != '0) && (RdM == Rs1E)) begin
            ForwardAE = FWD_MEM;
        end else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) begin
            ForwardAE = FWD_WB;
        end
        if (RegWriteM && (RdM != '0) && (RdM == Rs2E)) begin
            ForwardBE = FWD_MEM;
        end else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) begin
            ForwardBE = FWD_WB;
        end
    end

    // A load in E cannot forward in time to a dependent instruction in D
    always_comb begin
        lwStall = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
        stall_c = lwStall;
    end
`else
    logic e_hits_d;
    logic m_hits_d;
    logic unused_hz;

    // Source indices in E, the WB writer and the load flag are irrelevant
    // without forwarding (the register file writes before it reads)
    assign unused_hz = ^{Rs1E, Rs2E, RdW, RegWriteW, MemReadE};

    // Operands always come straight from the register file read
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
    end

    // Any pending writer in E or M that D depends on must drain first
    always_comb begin
        e_hits_d = RegWriteE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
        m_hits_d = RegWriteM && (RdM != '0) && ((RdM == Rs1D) || (RdM == Rs2D));
        stall_c  = e_hits_d | m_hits_d;
    end
`endif

    // A redirect overrides a stall: D and E are flushed instead of held
    always_comb begin
        StallF = stall_c & ~PCSrcE;
        StallD = stall_c & ~PCSrcE;
        FlushD = PCSrcE;
        FlushE = stall_c | PCSrcE;
    end

endmodule : hazard_unit

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage of the RV32 core.
// Holds the decoded operands and control for EX, applies MEM/WB forwarding to
// the ALU operands and instantiates the hazard unit that drives stall/flush.
// Build option EX_FORWARD_EN selects forwarding (see hazard_unit); with it
// undefined the operands always come from the register file read.
// Reset is synchronous, active-low; a flush loads an all-zero bubble.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int WIDTH  = CORE_WIDTH,
    parameter int REG_AW = CORE_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    // Decode stage
    input  logic [WIDTH-1:0]  RD1D,
    input  logic [WIDTH-1:0]  RD2D,
    input  logic [WIDTH-1:0]  ImmExtD,
    input  logic [WIDTH-1:0]  PCD,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic [2:0]        ALUControlD,
    input  logic              ALUSrcD,
    input  logic              RegWriteD,
    input  logic              MemReadD,
    input  logic              MemWriteD,
    input  logic              BranchD,
    input  logic              JumpD,
    // Later stages
    input  logic [WIDTH-1:0]  ALUResultM,
    input  logic [WIDTH-1:0]  ResultW,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ZeroE,
    // To the ALU and EX/MEM
    output logic [WIDTH-1:0]  SrcAE,
    output logic [WIDTH-1:0]  SrcBE,
    output logic [2:0]        ALUControlE,
    output logic [WIDTH-1:0]  WriteDataE,
    output logic [WIDTH-1:0]  PCE,
    output logic [WIDTH-1:0]  ImmExtE,
    output logic [REG_AW-1:0] RdE,
    output logic              RegWriteE,
    output logic              MemReadE,
    output logic              MemWriteE,
    // Hazard controls
    output logic              PCSrcE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD
);

    // E-stage registers and their next-state values
    logic [WIDTH-1:0]  rd1_q,      rd1_d;
    logic [WIDTH-1:0]  rd2_q,      rd2_d;
    logic [WIDTH-1:0]  imm_q,      imm_d;
    logic [WIDTH-1:0]  pc_q,       pc_d;
    logic [REG_AW-1:0] rs1_q,      rs1_d;
    logic [REG_AW-1:0] rs2_q,      rs2_d;
    logic [REG_AW-1:0] rd_q,       rd_d;
    logic [2:0]        aluctl_q,   aluctl_d;
    logic              alusrc_q,   alusrc_d;
    logic              regwrite_q, regwrite_d;
    logic              memread_q,  memread_d;
    logic              memwrite_q, memwrite_d;
    logic              branch_q,   branch_d;
    logic              jump_q,     jump_d;

    fwd_sel_t          fwd_a_sel;
    fwd_sel_t          fwd_b_sel;
    logic              flush_e;
    logic [WIDTH-1:0]  fwd_a;
    logic [WIDTH-1:0]  fwd_b;

    hazard_unit #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .Rs1E      (rs1_q),
        .Rs2E      (rs2_q),
        .RdE       (rd_q),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteE (regwrite_q),
        .MemReadE  (memread_q),
        .BranchE   (branch_q),
        .JumpE     (jump_q),
        .ZeroE     (ZeroE),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardAE (fwd_a_sel),
        .ForwardBE (fwd_b_sel),
        .PCSrcE    (PCSrcE),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .FlushE    (flush_e)
    );

    // Next E contents: the decoded instruction, or a bubble when flushed
    always_comb begin
        rd1_d      = RD1D;
        rd2_d      = RD2D;
        imm_d      = ImmExtD;
        pc_d       = PCD;
        rs1_d      = Rs1D;
        rs2_d      = Rs2D;
        rd_d       = RdD;
        aluctl_d   = ALUControlD;
        alusrc_d   = ALUSrcD;
        regwrite_d = RegWriteD;
        memread_d  = MemReadD;
        memwrite_d = MemWriteD;
        branch_d   = BranchD;
        jump_d     = JumpD;
        if (flush_e) begin
            rd1_d      = '0;
            rd2_d      = '0;
            imm_d      = '0;
            pc_d       = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
            aluctl_d   = ALU_ADD;
            alusrc_d   = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            branch_d   = 1'b0;
            jump_d     = 1'b0;
        end
    end

    // ID/EX register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            aluctl_q   <= ALU_ADD;
            alusrc_q   <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            branch_q   <= 1'b0;
            jump_q     <= 1'b0;
        end else begin
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            aluctl_q   <= aluctl_d;
            alusrc_q   <= alusrc_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            branch_q   <= branch_d;
            jump_q     <= jump_d;
        end
    end

    // Operand muxes driven by the hazard unit's forward selects
    always_comb begin
        fwd_a = rd1_q;
        fwd_b = rd2_q;
        case (fwd_a_sel)
            FWD_MEM: fwd_a = ALUResultM;
            FWD_WB:  fwd_a = ResultW;
            default: fwd_a = rd1_q;
        endcase
        case (fwd_b_sel)
            FWD_MEM: fwd_b = ALUResultM;
            FWD_WB:  fwd_b = ResultW;
            default: fwd_b = rd2_q;
        endcase
    end

    // Outputs to the ALU and the EX/MEM register
    always_comb begin
        SrcAE       = fwd_a;
        WriteDataE  = fwd_b;
        SrcBE       = alusrc_q ? imm_q : fwd_b;
        ALUControlE = aluctl_q;
        PCE         = pc_q;
        ImmExtE     = imm_q;
        RdE         = rd_q;
        RegWriteE   = regwrite_q;
        MemReadE    = memread_q;
        MemWriteE   = memwrite_q;
    end

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; expectations adapt to the EX_FORWARD_EN build.
module tb_id_ex_stage;
    import core_pkg::*;

`ifdef EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] RD1D, RD2D, ImmExtD, PCD, ALUResultM, ResultW;
    logic [4:0]  Rs1D, Rs2D, RdD, RdM, RdW;
    logic [2:0]  ALUControlD;
    logic        ALUSrcD, RegWriteD, MemReadD, MemWriteD, BranchD, JumpD;
    logic        RegWriteM, RegWriteW, ZeroE;
    logic [31:0] SrcAE, SrcBE, WriteDataE, PCE, ImmExtE;
    logic [2:0]  ALUControlE;
    logic [4:0]  RdE;
    logic        RegWriteE, MemReadE, MemWriteE, PCSrcE, StallF, StallD, FlushD;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUControlD(ALUControlD),
        .ALUSrcD(ALUSrcD), .RegWriteD(RegWriteD), .MemReadD(MemReadD),
        .MemWriteD(MemWriteD), .BranchD(BranchD), .JumpD(JumpD),
        .ALUResultM(ALUResultM), .ResultW(ResultW), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ZeroE(ZeroE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE),
        .WriteDataE(WriteDataE), .PCE(PCE), .ImmExtE(ImmExtE), .RdE(RdE),
        .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MemWriteE(MemWriteE),
        .PCSrcE(PCSrcE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD)
    );

    task automatic clear_inputs();
        RD1D = '0; RD2D = '0; ImmExtD = '0; PCD = '0;
        Rs1D = '0; Rs2D = '0; RdD = '0; ALUControlD = '0;
        ALUSrcD = 0; RegWriteD = 0; MemReadD = 0; MemWriteD = 0; BranchD = 0; JumpD = 0;
        ALUResultM = '0; ResultW = '0; RdM = '0; RdW = '0;
        RegWriteM = 0; RegWriteW = 0; ZeroE = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        RD1D = 32'hDEAD0001; RD2D = 32'hDEAD0002; ImmExtD = 32'hDEAD0003; PCD = 32'hDEAD0004;
        Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd3; ALUControlD = 3'b111;
        ALUSrcD = 1; RegWriteD = 1; MemReadD = 1; MemWriteD = 1; BranchD = 1; JumpD = 1;
        ZeroE = 1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (SrcAE !== 32'h0) begin n_fail++; $display("FAIL reset_srca: got %h want 0", SrcAE); end
        n_checks++; if (SrcBE !== 32'h0) begin n_fail++; $display("FAIL reset_srcb: got %h want 0", SrcBE); end
        n_checks++; if (WriteDataE !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", WriteDataE); end
        n_checks++; if (PCE !== 32'h0 || ImmExtE !== 32'h0) begin n_fail++; $display("FAIL reset_pc_imm: got %h/%h want 0/0", PCE, ImmExtE); end
        n_checks++; if (ALUControlE !== 3'b000 || RdE !== 5'd0) begin n_fail++; $display("FAIL reset_ctl_rd: got %b/%0d want 000/0", ALUControlE, RdE); end
        n_checks++; if ({RegWriteE, MemReadE, MemWriteE} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b want 000", {RegWriteE, MemReadE, MemWriteE}); end
        n_checks++; if ({PCSrcE, StallF, StallD, FlushD} !== 4'b0000) begin n_fail++; $display("FAIL reset_hazard: got %b want 0000", {PCSrcE, StallF, StallD, FlushD}); end
        clear_inputs();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_capture();
        clear_inputs();
        RD1D = 32'h1111; RD2D = 32'h2222; ImmExtD = 32'h33; PCD = 32'h100;
        Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd6; ALUControlD = ALU_SUB;
        RegWriteD = 1; MemWriteD = 1;
        step();
        n_checks++; if (SrcAE !== 32'h1111) begin n_fail++; $display("FAIL cap_srca: got %h want 1111", SrcAE); end
        n_checks++; if (SrcBE !== 32'h2222 || WriteDataE !== 32'h2222) begin n_fail++; $display("FAIL cap_srcb: got %h/%h want 2222/2222", SrcBE, WriteDataE); end
        n_checks++; if (PCE !== 32'h100 || ImmExtE !== 32'h33) begin n_fail++; $display("FAIL cap_pc_imm: got %h/%h want 100/33", PCE, ImmExtE); end
        n_checks++; if (RdE !== 5'd6 || ALUControlE !== 3'b001) begin n_fail++; $display("FAIL cap_rd_ctl: got %0d/%b want 6/001", RdE, ALUControlE); end
        n_checks++; if ({RegWriteE, MemReadE, MemWriteE} !== 3'b101) begin n_fail++; $display("FAIL cap_ctrl: got %b want 101", {RegWriteE, MemReadE, MemWriteE}); end
        ALUSrcD = 1; ImmExtD = 32'h44; ALUControlD = ALU_PASSB;
        step();
        n_checks++; if (SrcBE !== 32'h44) begin n_fail++; $display("FAIL cap_alusrc: got %h want 44", SrcBE); end
        n_checks++; if (WriteDataE !== 32'h2222 || ALUControlE !== 3'b101) begin n_fail++; $display("FAIL cap_wdata_passb: got %h/%b want 2222/101", WriteDataE, ALUControlE); end
    endtask

    task automatic test_mem_forward();
        clear_inputs();
        Rs1D = 5'd5; RD1D = 32'h99;
        step();
        clear_inputs();
        ALUResultM = 32'h10; RdM = 5'd5; RegWriteM = 1;
        #1;
        n_checks++; if (SrcAE !== (FWD ? 32'h10 : 32'h99)) begin n_fail++; $display("FAIL mem_fwd_a: got %h want %h", SrcAE, (FWD ? 32'h10 : 32'h99)); end
        RdM = 5'd0;
        #1;
        n_checks++; if (SrcAE !== 32'h99) begin n_fail++; $display("FAIL mem_fwd_rd0: got %h want 99", SrcAE); end
        RegWriteM = 0; RdW = 5'd5; ResultW = 32'h20; RegWriteW = 1;
        #1;
        n_checks++; if (SrcAE !== (FWD ? 32'h20 : 32'h99)) begin n_fail++; $display("FAIL wb_fwd_a: got %h want %h", SrcAE, (FWD ? 32'h20 : 32'h99)); end
        clear_inputs();
        Rs1D = 5'd0; RD1D = 32'h5A;
        step();
        RegWriteM = 1; RdM = 5'd0; ALUResultM = 32'h10;
        RegWriteW = 1; RdW = 5'd0; ResultW = 32'h20;
        #1;
        n_checks++; if (SrcAE !== 32'h5A) begin n_fail++; $display("FAIL x0_no_fwd: got %h want 5a", SrcAE); end
    endtask

    task automatic test_priority();
        clear_inputs();
        Rs2D = 5'd7; RD2D = 32'h77; ImmExtD = 32'h5;
        step();
        RdM = 5'd7; RdW = 5'd7; ALUResultM = 32'hA; ResultW = 32'hB; RegWriteM = 1; RegWriteW = 1;
        Rs2D = 5'd0; RD2D = '0; ImmExtD = '0;
        #1;
        n_checks++; if (SrcBE !== (FWD ? 32'hA : 32'h77) || WriteDataE !== (FWD ? 32'hA : 32'h77)) begin n_fail++; $display("FAIL mem_over_wb: got %h/%h want %h", SrcBE, WriteDataE, (FWD ? 32'hA : 32'h77)); end
        RegWriteM = 0;
        #1;
        n_checks++; if (WriteDataE !== (FWD ? 32'hB : 32'h77)) begin n_fail++; $display("FAIL wb_fwd_b: got %h want %h", WriteDataE, (FWD ? 32'hB : 32'h77)); end
    endtask

    task automatic test_load_use();
        clear_inputs();
        MemReadD = 1; RegWriteD = 1; RdD = 5'd3;
        step();
        clear_inputs();
        Rs1D = 5'd3; RegWriteD = 1; RdD = 5'd9; RD1D = 32'h123;
        #1;
        n_checks++; if ({StallF, StallD, FlushD, PCSrcE} !== 4'b1100) begin n_fail++; $display("FAIL lu_stall: got %b want 1100", {StallF, StallD, FlushD, PCSrcE}); end
        step();
        n_checks++; if ({RegWriteE, MemReadE} !== 2'b00 || RdE !== 5'd0) begin n_fail++; $display("FAIL lu_bubble: got %b rd %0d want 00 rd 0", {RegWriteE, MemReadE}, RdE); end
        n_checks++; if ({StallF, StallD} !== 2'b00) begin n_fail++; $display("FAIL lu_one_cycle: got %b want 00", {StallF, StallD}); end
        step();
        n_checks++; if (RegWriteE !== 1'b1 || RdE !== 5'd9 || SrcAE !== 32'h123) begin n_fail++; $display("FAIL lu_resume: got %b/%0d/%h want 1/9/123", RegWriteE, RdE, SrcAE); end
        clear_inputs();
        MemReadD = 1; RegWriteD = 1; RdD = 5'd0;
        step();
        clear_inputs();
        #1;
        n_checks++; if (StallF !== 1'b0) begin n_fail++; $display("FAIL lu_rd0: got %b want 0", StallF); end
    endtask

    task automatic test_branch_vs_stall();
        clear_inputs();
        BranchD = 1; MemReadD = 1; RegWriteD = 1; RdD = 5'd3; ALUControlD = ALU_SUB;
        step();
        clear_inputs();
        Rs1D = 5'd3; RegWriteD = 1; RdD = 5'd10; ZeroE = 0;
        #1;
        n_checks++; if ({PCSrcE, StallF} !== 2'b01) begin n_fail++; $display("FAIL br_not_taken: got %b want 01", {PCSrcE, StallF}); end
        ZeroE = 1;
        #1;
        n_checks++; if ({PCSrcE, FlushD, StallF, StallD} !== 4'b1100) begin n_fail++; $display("FAIL br_over_stall: got %b want 1100", {PCSrcE, FlushD, StallF, StallD}); end
        step();
        n_checks++; if ({RegWriteE, MemReadE, MemWriteE, PCSrcE} !== 4'b0000 || ALUControlE !== 3'b000 || RdE !== 5'd0) begin n_fail++; $display("FAIL br_flush_e: got %b ctl %b rd %0d want 0000 ctl 000 rd 0", {RegWriteE, MemReadE, MemWriteE, PCSrcE}, ALUControlE, RdE); end
    endtask

    task automatic test_jump();
        clear_inputs();
        JumpD = 1; RegWriteD = 1; RdD = 5'd1; PCD = 32'h200;
        step();
        clear_inputs();
        #1;
        n_checks++; if ({PCSrcE, FlushD, PCE} !== {2'b11, 32'h200}) begin n_fail++; $display("FAIL jump_redirect: got %b pc %h want 11 pc 200", {PCSrcE, FlushD}, PCE); end
        step();
        n_checks++; if ({PCSrcE, RegWriteE} !== 2'b00 || PCE !== 32'h0) begin n_fail++; $display("FAIL jump_flush: got %b pc %h want 00 pc 0", {PCSrcE, RegWriteE}, PCE); end
    endtask

    task automatic test_no_fwd_stall();
        clear_inputs();
        RegWriteD = 1; RdD = 5'd4; Rs1D = 5'd2; RD1D = 32'h55;
        step();
        clear_inputs();
        Rs2D = 5'd4; RegWriteM = 1; RdM = 5'd2; ALUResultM = 32'hEE;
        #1;
        n_checks++; if ({StallF, StallD} !== (FWD ? 2'b00 : 2'b11)) begin n_fail++; $display("FAIL nf_e_stall: got %b want %b", {StallF, StallD}, (FWD ? 2'b00 : 2'b11)); end
        n_checks++; if (SrcAE !== (FWD ? 32'hEE : 32'h55)) begin n_fail++; $display("FAIL nf_srca: got %h want %h", SrcAE, (FWD ? 32'hEE : 32'h55)); end
        Rs2D = 5'd0; Rs1D = 5'd2;
        #1;
        n_checks++; if (StallD !== (FWD ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL nf_m_stall: got %b want %b", StallD, (FWD ? 1'b0 : 1'b1)); end
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        MemReadD = 1; RegWriteD = 1; RdD = 5'd3;
        step();
        clear_inputs();
        Rs1D = 5'd3;
        #1;
        n_checks++; if (StallF !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got %b want 1", StallF); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (StallF !== 1'b1) begin n_fail++; $display("FAIL rst_mid_hold: got %b want 1", StallF); end
        step();
        n_checks++; if ({StallF, StallD, MemReadE} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_clear: got %b want 000", {StallF, StallD, MemReadE}); end
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_capture();
        test_mem_forward();
        test_priority();
        test_load_use();
        test_branch_vs_stall();
        test_jump();
        test_no_fwd_stall();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_id_ex_stage

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the pipelined RV32 core. It registers decoded operands and control at the ID/EX boundary and forwards results from MEM/WB onto the operands. It detects load-use hazards and branch/jump redirects, and drives the stall and flush controls. Its outputs feed the ALU directly: SrcAE, SrcBE and ALUControlE. It consumes the ALU's ZeroE flag to resolve branches.

## Interface
- WIDTH, 32, datapath width
- REG_AW, 5, register-index width
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- RD1D, RD2D, ImmExtD, PCD  in  WIDTH each  decoded operands / immediate / PC
- Rs1D, Rs2D, RdD  in  REG_AW each  register indices
- ALUControlD  in  3  ALU op
- ALUSrcD, RegWriteD, MemReadD, MemWriteD, BranchD, JumpD  in  1 each  decoded control
- ALUResultM, ResultW  in  WIDTH each  MEM / WB result
- RdM, RdW  in  REG_AW each  MEM / WB destination
- RegWriteM, RegWriteW  in  1 each  MEM / WB write enable
- ZeroE  in  1  ALU flag (1 = operands differ, used for bne)
- SrcAE, SrcBE  out  WIDTH each  ALU operands
- ALUControlE  out  3  registered ALU op
- WriteDataE, PCE, ImmExtE  out  WIDTH each  store data / PC / immediate to EX/MEM
- RdE  out  REG_AW  destination index
- RegWriteE, MemReadE, MemWriteE  out  1 each  registered control
- PCSrcE  out  1  redirect fetch
- StallF, StallD, FlushD  out  1 each  hazard controls

## Operation
- **ID/EX register.** On a rising clk edge:
  - If !rst_n or FlushE: every E register loads 0. This includes the internal Rs1E, Rs2E, BranchE, JumpE and ALUSrcE, and gives ALUControlE = 000 and RdE = 0. The result is a bubble.
  - Otherwise: all D inputs are captured.
- **FlushE** = lwStall | PCSrcE.
- **Load-use detect.** lwStall = MemReadE & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)).
- **Redirect.** PCSrcE = (BranchE & ZeroE) | JumpE.
- **Stall/flush outputs.**
  - StallF = StallD = lwStall & !PCSrcE. A redirect overrides a stall.
  - FlushD = PCSrcE.
- **Forward A.** Priority order:
  - RegWriteM & RdM != 0 & RdM == Rs1E → ALUResultM;
  - else RegWriteW & RdW != 0 & RdW == Rs1E → ResultW;
  - else RD1E.
  - MEM wins over WB. x0 is never forwarded.
- **Forward B.** Same rule on Rs2E/RD2E; the result goes to WriteDataE.
- **Operand outputs.**
  - SrcAE = forwarded A.
  - SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- **Reset values.** All registered outputs are 0.
  - During reset, PCSrcE = 0 and the stall/flush outputs are 0.
  - SrcAE = SrcBE = 0.

## Timing
- One-cycle latency from D inputs to E outputs.
- Forwarding, hazard detection and PCSrcE are purely combinational from E registers and M/W inputs.
- A load-use hazard costs exactly one bubble. F/D hold for 1 cycle while E loads the bubble.
- A taken branch or jump flushes D and E on the next edge (2-instruction penalty).
- **lwStall and PCSrcE in the same cycle:** no stall; D and E are both flushed.
- **Reset asserted mid-stall:** the state clears on that edge and the stall drops the cycle after.

## Configuration
- `EX_FORWARD_EN` defined:
  - forwarding as above;
  - only load-use hazards stall.
- Undefined:
  - A/B always take RD1E/RD2E.
  - The stall condition becomes lwStall_nf = any E or M stage with RegWrite, Rd != 0 and Rd matching Rs1D or Rs2D.
  - The register file writes-before-reads, so WB needs no stall.
  - StallF/StallD/FlushE use lwStall_nf in place of lwStall, with the same redirect priority.

## Structure
- **Shared package `core_pkg`:**
  - ALU op constants, matching the ALU encoding: ADD 000, SUB 001, AND 010, OR 011, XOR 100, PASSB 101 (LUI), SLL 110, SRL 111;
  - forward-select enum fwd_sel_t {FWD_RF, FWD_WB, FWD_MEM};
  - WIDTH and REG_AW defaults.
- **Sub-module `hazard_unit`:** combinational. It computes the forward selects, lwStall, StallF, StallD, FlushD and FlushE. The ID/EX registers and operand muxes stay in id_ex_stage.

## Test plan
- **Reset.** rst_n=0 for 2 cycles with all D inputs non-zero → all E outputs 0, PCSrcE=0, no stall.
- **MEM forward.** add x5 in MEM (ALUResultM=0x10, RdM=5, RegWriteM=1); E has Rs1E=5, RD1E=0x99 → SrcAE=0x10. Same with RdM=0 → SrcAE=0x99.
- **MEM over WB priority.** RdM=RdW=7, ALUResultM=0xA, ResultW=0xB, Rs2E=7, ALUSrcE=0 → SrcBE=0xA and WriteDataE=0xA.
- **Load-use.** lw x3 in E (MemReadE=1, RdE=3); D has Rs1D=3 → StallF=StallD=1 for exactly 1 cycle; next cycle E is a bubble with RegWriteE=0.
- **Branch vs stall.** BranchE=1, ZeroE=1 with a concurrent load-use match → PCSrcE=1, FlushD=1, StallF=0; next cycle all E control is 0.
- **No-forward build.** Without `EX_FORWARD_EN`: RegWriteE=1, RdE=4, Rs2D=4 → StallD=1 and, that cycle, SrcAE = RD1E regardless of the M/W match.
